// File: rtl/mp3_frame_sync.sv
// mp3_frame_sync: MPEG-1 Layer III sync hunter, header checker and
// payload forwarder with lock tracking across consecutive frames.
module mp3_frame_sync #(
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic             frame_start,
  output logic [1:0]       hdr_sr_idx,
  output logic [1:0]       hdr_mode,
  output logic             hdr_crc,
  output logic [10:0]      frame_len,
  output logic             locked,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] sync_loss_count
);

  typedef enum logic [2:0] {
    S_HUNT, S_H1, S_H2, S_H3, S_CRC, S_PAY, S_CHK
  } state_t;

  localparam logic [7:0] LOCK_TH = 8'(LOCK_COUNT - 1);

  state_t      state;
  logic        run;
  logic        from_chk;
  logic        p_crc;
  logic        p_pad;
  logic        crc_cnt;
  logic        pay_first;
  logic [3:0]  p_br;
  logic [1:0]  p_sr;
  logic [10:0] pay_rem;
  logic [7:0]  cons_cnt;

  logic        acc;
  logic        is_sync;
  logic        is_id;
  logic        hdr_ok;
  logic        reject;
  logic [10:0] len;
  logic [10:0] pay_n;
  logic [7:0]  cons_nxt;

  function automatic logic [8:0] kbps(input logic [3:0] br);
    case (br)
      4'd1:    kbps = 9'd32;
      4'd2:    kbps = 9'd40;
      4'd3:    kbps = 9'd48;
      4'd4:    kbps = 9'd56;
      4'd5:    kbps = 9'd64;
      4'd6:    kbps = 9'd80;
      4'd7:    kbps = 9'd96;
      4'd8:    kbps = 9'd112;
      4'd9:    kbps = 9'd128;
      4'd10:   kbps = 9'd160;
      4'd11:   kbps = 9'd192;
      4'd12:   kbps = 9'd224;
      4'd13:   kbps = 9'd256;
      4'd14:   kbps = 9'd320;
      default: kbps = 9'd0;
    endcase
  endfunction

  // 44.1 kHz has no cheap closed form, so it is tabulated.
  function automatic logic [10:0] len44(input logic [3:0] br);
    case (br)
      4'd1:    len44 = 11'd104;
      4'd2:    len44 = 11'd130;
      4'd3:    len44 = 11'd156;
      4'd4:    len44 = 11'd182;
      4'd5:    len44 = 11'd208;
      4'd6:    len44 = 11'd261;
      4'd7:    len44 = 11'd313;
      4'd8:    len44 = 11'd365;
      4'd9:    len44 = 11'd417;
      4'd10:   len44 = 11'd522;
      4'd11:   len44 = 11'd626;
      4'd12:   len44 = 11'd731;
      4'd13:   len44 = 11'd835;
      4'd14:   len44 = 11'd1044;
      default: len44 = 11'd0;
    endcase
  endfunction

  // 48 kHz is 3*kbps, 32 kHz is floor(4.5*kbps).
  function automatic logic [10:0] base_len(
    input logic [3:0] br,
    input logic [1:0] sr
  );
    logic [11:0] k;
    logic [11:0] t;
    k = {3'd0, kbps(br)};
    case (sr)
      2'd1:    t = k * 12'd3;
      2'd2:    t = (k * 12'd9) >> 1;
      default: t = {1'b0, len44(br)};
    endcase
    return t[10:0];
  endfunction

  assign acc      = in_valid & in_ready;
  assign is_sync  = (in_data == 8'hFF);
  assign is_id    = (in_data[7:1] == 7'b1111101);
  assign hdr_ok   = (in_data[7:4] != 4'h0) &&
                    (in_data[7:4] != 4'hF) &&
                    (in_data[3:2] != 2'd3);
  assign len      = base_len(p_br, p_sr) + {10'd0, p_pad};
  assign pay_n    = len - (p_crc ? 11'd6 : 11'd4);
  assign cons_nxt = (cons_cnt == 8'hFF) ? cons_cnt : cons_cnt + 8'd1;
  assign in_ready = run &
                    ((state != S_PAY) | ~out_valid | out_ready);

  // Header rejections that break a chain of correctly spaced frames.
  always_comb begin
    reject = 1'b0;
    if (acc) begin
      case (state)
        S_CHK:   reject = ~is_sync;
        S_H1:    reject = from_chk & ~is_id & ~is_sync;
        S_H2:    reject = from_chk & ~hdr_ok;
        default: reject = 1'b0;
      endcase
    end
  end

  // Parser FSM, output register and lock/statistics counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_HUNT;
      run             <= 1'b0;
      from_chk        <= 1'b0;
      p_crc           <= 1'b0;
      p_pad           <= 1'b0;
      p_br            <= '0;
      p_sr            <= '0;
      crc_cnt         <= 1'b0;
      pay_first       <= 1'b0;
      pay_rem         <= '0;
      cons_cnt        <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_first       <= 1'b0;
      out_last        <= 1'b0;
      frame_start     <= 1'b0;
      hdr_sr_idx      <= '0;
      hdr_mode        <= '0;
      hdr_crc         <= 1'b0;
      frame_len       <= '0;
      locked          <= 1'b0;
      frame_count     <= '0;
      sync_loss_count <= '0;
    end else begin
      run         <= 1'b1;
      frame_start <= 1'b0;
      if (out_ready) out_valid <= 1'b0;

      if (reject) begin
        locked   <= 1'b0;
        cons_cnt <= '0;
        from_chk <= 1'b0;
        state    <= S_HUNT;
        if (locked && !(&sync_loss_count))
          sync_loss_count <= sync_loss_count + CNT_W'(1);
      end else if (acc) begin
        case (state)
          S_HUNT: begin
            if (is_sync) begin
              state    <= S_H1;
              from_chk <= 1'b0;
            end
          end
          S_CHK: begin
            state    <= S_H1;
            from_chk <= 1'b1;
          end
          S_H1: begin
            if (is_id) begin
              p_crc <= ~in_data[0];
              state <= S_H2;
            end else if (!is_sync) begin
              state <= S_HUNT;
            end
          end
          S_H2: begin
            if (hdr_ok) begin
              p_br  <= in_data[7:4];
              p_sr  <= in_data[3:2];
              p_pad <= in_data[1];
              state <= S_H3;
            end else begin
              state <= is_sync ? S_H1 : S_HUNT;
            end
          end
          S_H3: begin
            hdr_mode    <= in_data[7:6];
            hdr_sr_idx  <= p_sr;
            hdr_crc     <= p_crc;
            frame_len   <= len;
            pay_rem     <= pay_n;
            pay_first   <= 1'b1;
            crc_cnt     <= 1'b0;
            frame_start <= 1'b1;
            frame_count <= frame_count + CNT_W'(1);
            if (from_chk) begin
              cons_cnt <= cons_nxt;
              if (cons_nxt >= LOCK_TH) locked <= 1'b1;
            end else begin
              cons_cnt <= '0;
              if (LOCK_COUNT <= 1) locked <= 1'b1;
            end
            state <= p_crc ? S_CRC : S_PAY;
          end
          S_CRC: begin
            crc_cnt <= 1'b1;
            if (crc_cnt) state <= S_PAY;
          end
          S_PAY: begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_first <= pay_first;
            out_last  <= (pay_rem == 11'd1);
            pay_first <= 1'b0;
            pay_rem   <= pay_rem - 11'd1;
            if (pay_rem == 11'd1) state <= S_CHK;
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mp3_frame_sync.sv
// tb_mp3_frame_sync: randomized bench for mp3_frame_sync against
// a frame-level reference built from the header bit layout.
module tb_mp3_frame_sync;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_first;
  logic        out_last;
  logic        frame_start;
  logic [1:0]  hdr_sr_idx;
  logic [1:0]  hdr_mode;
  logic        hdr_crc;
  logic [10:0] frame_len;
  logic        locked;
  logic [15:0] frame_count;
  logic [15:0] sync_loss_count;

  mp3_frame_sync dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_first(out_first),
    .out_last(out_last),
    .frame_start(frame_start),
    .hdr_sr_idx(hdr_sr_idx),
    .hdr_mode(hdr_mode),
    .hdr_crc(hdr_crc),
    .frame_len(frame_len),
    .locked(locked),
    .frame_count(frame_count),
    .sync_loss_count(sync_loss_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int fs_cnt = 0;
  int stab_err = 0;
  int drv_cycles = 0;
  int run_len = 0;

  logic [7:0]  stim[$];
  logic [9:0]  exp_q[$];
  logic [9:0]  got_q[$];
  logic [16:0] e_hdr[$];
  logic [16:0] g_hdr[$];
  logic        hold_v = 1'b0;
  logic [9:0]  held = '0;

  int kbps_tab[15] = '{0, 32, 40, 48, 56, 64, 80, 96,
                       112, 128, 160, 192, 224, 256, 320};

  // Observe handshakes, header snapshots and output stability.
  always @(negedge clock) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && (!out_valid ||
          {out_first, out_last, out_data} !== held))
        stab_err++;
      if (out_valid && out_ready)
        got_q.push_back({out_first, out_last, out_data});
      hold_v = out_valid && !out_ready;
      held = {out_first, out_last, out_data};
      if (frame_start) begin
        fs_cnt++;
        g_hdr.push_back({frame_len, hdr_sr_idx, hdr_mode,
                         hdr_crc, locked});
      end
    end
  end

  function automatic int model_len(input logic [7:0] b2);
    int hz;
    case (b2[3:2])
      2'd0:    hz = 44100;
      2'd1:    hz = 48000;
      default: hz = 32000;
    endcase
    return (144 * kbps_tab[b2[7:4]] * 1000) / hz + int'(b2[1]);
  endfunction

  task automatic add_frame(input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input bit chained);
    int len;
    int n;
    logic [7:0] d;
    len = model_len(b2);
    n = len - 4 - (b1[0] ? 0 : 2);
    stim.push_back(8'hFF);
    stim.push_back(b1);
    stim.push_back(b2);
    stim.push_back(b3);
    if (!b1[0]) repeat (2) stim.push_back(8'($urandom));
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      stim.push_back(d);
      exp_q.push_back({i == 0, i == n - 1, d});
    end
    run_len = chained ? run_len + 1 : 1;
    e_hdr.push_back({11'(len), b2[3:2], b3[7:6], !b1[0],
                     run_len >= 3});
  endtask

  task automatic clear_model();
    stim.delete();
    exp_q.delete();
    got_q.delete();
    e_hdr.delete();
    g_hdr.delete();
    fs_cnt = 0;
    stab_err = 0;
    run_len = 0;
  endtask

  task automatic reset_dut();
    @(posedge clock);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    clear_model();
    #1;
    reset = 1'b0;
  endtask

  task automatic drive(input int nbytes, input bit gaps,
                       input bit rnd_rdy, input bit drain);
    int idx;
    idx = 0;
    drv_cycles = 0;
    while (idx < nbytes && drv_cycles < 60000) begin
      @(posedge clock);
      #1;
      drv_cycles++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data = stim[idx];
      end
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      if (in_valid && in_ready) idx++;
    end
    checks++;
    if (idx != nbytes) begin
      failures++;
      $display("FAIL drive_timeout: sent %0d bytes, needed %0d",
               idx, nbytes);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (drain) begin
      out_ready = 1'b1;
      repeat (4) @(posedge clock);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({in_ready, out_valid, out_data, out_first, out_last,
         frame_start, hdr_sr_idx, hdr_mode, hdr_crc, frame_len,
         locked, frame_count, sync_loss_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b len=%0d cnt=%0d rdy=%b, need all 0",
               out_valid, frame_len, frame_count, in_ready);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b, need 1", in_ready);
    end
  endtask

  task automatic test_lock_sequence();
    reset_dut();
    for (int k = 0; k < 3; k++)
      add_frame(8'hFB, 8'h90, 8'h00, k > 0);
    drive(stim.size(), 1'b0, 1'b0, 1'b1);
    checks++;
    if (drv_cycles != stim.size()) begin
      failures++;
      $display("FAIL t1_bubbles: got %0d cycles, need %0d",
               drv_cycles, stim.size());
    end
    checks++;
    if (fs_cnt != 3) begin
      failures++;
      $display("FAIL t1_frame_start: got %0d, need 3", fs_cnt);
    end
    for (int i = 0; i < g_hdr.size() && i < e_hdr.size(); i++) begin
      checks++;
      if (g_hdr[i] !== e_hdr[i]) begin
        failures++;
        $display("FAIL t1_hdr%0d: got %h, need %h", i, g_hdr[i], e_hdr[i]);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t1_bytes: got %0d, need %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t1_byte%0d: got %h, need %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({locked, frame_count} !== {1'b1, 16'd3}) begin
      failures++;
      $display("FAIL t1_lock: got locked=%b count=%0d, need 1/3",
               locked, frame_count);
    end
  endtask

  task automatic test_crc_header();
    reset_dut();
    add_frame(8'hFA, 8'h92, 8'h40, 1'b0);
    drive(stim.size(), 1'b1, 1'b0, 1'b1);
    checks++;
    if ({frame_len, hdr_crc, hdr_mode} !== {11'd418, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL t2_fields: got len=%0d crc=%b mode=%0d, need 418/1/1",
               frame_len, hdr_crc, hdr_mode);
    end
    checks++;
    if (fs_cnt != 1 || got_q.size() != 412) begin
      failures++;
      $display("FAIL t2_counts: got fs=%0d bytes=%0d, need 1/412",
               fs_cnt, got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t2_byte%0d: got %h, need %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_garbage_sync();
    reset_dut();
    stim.push_back(8'h00);
    stim.push_back(8'hFF);
    add_frame(8'hFB, 8'h94, 8'h00, 1'b0);
    drive(stim.size(), 1'b1, 1'b0, 1'b1);
    checks++;
    if ({fs_cnt == 1, hdr_sr_idx, frame_len} !== {1'b1, 2'd1, 11'd384}) begin
      failures++;
      $display("FAIL t3_fields: got fs=%0d sr=%0d len=%0d, need 1/1/384",
               fs_cnt, hdr_sr_idx, frame_len);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t3_bytes: got %0d, need %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t3_byte%0d: got %h, need %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_sync_loss();
    reset_dut();
    for (int k = 0; k < 3; k++)
      add_frame(8'hFB, 8'h90, 8'h00, k > 0);
    stim.push_back(8'h12);
    stim.push_back(8'h00);
    repeat (3) stim.push_back(8'($urandom_range(0, 254)));
    add_frame(8'hFB, 8'h90, 8'h00, 1'b0);
    drive(stim.size(), 1'b1, 1'b0, 1'b1);
    checks++;
    if ({locked, sync_loss_count, frame_count} !==
        {1'b0, 16'd1, 16'd4}) begin
      failures++;
      $display("FAIL t4_loss: got locked=%b loss=%0d count=%0d, need 0/1/4",
               locked, sync_loss_count, frame_count);
    end
    checks++;
    if (fs_cnt != 4 || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t4_counts: got fs=%0d bytes=%0d, need 4/%0d",
               fs_cnt, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < g_hdr.size() && i < e_hdr.size(); i++) begin
      checks++;
      if (g_hdr[i] !== e_hdr[i]) begin
        failures++;
        $display("FAIL t4_hdr%0d: got %h, need %h", i, g_hdr[i], e_hdr[i]);
      end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t4_byte%0d: got %h, need %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bad_headers();
    logic [7:0] bad[13];
    bad = '{8'hFF, 8'hFB, 8'hF0, 8'h00, 8'hFF, 8'hFB, 8'h9C,
            8'h00, 8'hFF, 8'hE3, 8'h12, 8'h34, 8'h56};
    reset_dut();
    foreach (bad[i]) stim.push_back(bad[i]);
    drive(stim.size(), 1'b0, 1'b0, 1'b1);
    checks++;
    if (fs_cnt != 0 || got_q.size() != 0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL t5_reject: got fs=%0d bytes=%0d count=%0d, need 0/0/0",
               fs_cnt, got_q.size(), frame_count);
    end
  endtask

  task automatic test_random_backpressure();
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      b1 = $urandom_range(0, 1) ? 8'hFA : 8'hFB;
      b2 = {4'($urandom_range(1, 9)), 2'($urandom_range(0, 2)),
            2'($urandom)};
      b3 = 8'($urandom);
      add_frame(b1, b2, b3, k > 0);
    end
    drive(stim.size(), 1'b1, 1'b1, 1'b1);
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL t6_stable: got %0d changes under stall, need 0",
               stab_err);
    end
    checks++;
    if (fs_cnt != 4 || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t6_counts: got fs=%0d bytes=%0d, need 4/%0d",
               fs_cnt, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < g_hdr.size() && i < e_hdr.size(); i++) begin
      checks++;
      if (g_hdr[i] !== e_hdr[i]) begin
        failures++;
        $display("FAIL t6_hdr%0d: got %h, need %h", i, g_hdr[i], e_hdr[i]);
      end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t6_byte%0d: got %h, need %h", i, got_q[i], exp_q[i]);
      end
    end

    clear_model();
    add_frame(8'hFB, 8'h90, 8'h00, 1'b0);
    drive(stim.size() / 2, 1'b1, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({in_ready, out_valid, out_data, out_first, out_last,
         frame_start, hdr_sr_idx, hdr_mode, hdr_crc, frame_len,
         locked, frame_count, sync_loss_count} !== '0) begin
      failures++;
      $display("FAIL t6_reset: got valid=%b last=%b len=%0d cnt=%0d, need all 0",
               out_valid, out_last, frame_len, frame_count);
    end
    checks++;
    if (got_q.size() == 0 || got_q.size() > exp_q.size()) begin
      failures++;
      $display("FAIL t6_partial: got %0d bytes, need 1..%0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i][8]) begin
        failures++;
        $display("FAIL t6_pbyte%0d: got %h, need %h without last",
                 i, got_q[i], exp_q[i]);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_crc_header();
    test_garbage_sync();
    test_sync_loss();
    test_bad_headers();
    test_random_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
